// File: rtl/xadc_drp_responder.sv
// XADC DRP slave and conversion-sequencer stand-in.
// Answers DRP reads/writes with fixed latency and emulates a free-running conversion
// sequence that loads ch_data_in into the status registers of the demo channels.
module xadc_drp_responder #(
    parameter int unsigned LATENCY     = 4,   // 1..15
    parameter int unsigned CONV_CYCLES = 104  // >= 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    output logic        prot_err,
    input  logic [15:0] ch_data_in,
    output logic [4:0]  channel_out,
    output logic        eoc_out,
    output logic        eos_out
);

    localparam int unsigned CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // Demo channel sequence: status address of each slot
    function automatic logic [4:0] seq_ch(input logic [3:0] i);
        case (i)
            4'd0:    seq_ch = 5'h10;
            4'd1:    seq_ch = 5'h11;
            4'd2:    seq_ch = 5'h19;
            4'd3:    seq_ch = 5'h12;
            4'd4:    seq_ch = 5'h1A;
            4'd5:    seq_ch = 5'h1B;
            4'd6:    seq_ch = 5'h18;
            4'd7:    seq_ch = 5'h13;
            4'd8:    seq_ch = 5'h03;
            default: seq_ch = 5'h10;
        endcase
    endfunction

    logic [15:0]   regs [128];
    logic          state;
    logic [3:0]    lat_cnt;
    logic          req_we;
    logic [6:0]    req_addr;
    logic [15:0]   req_di;
    logic [15:0]   snap;
    logic [CW-1:0] conv_cnt;
    logic [3:0]    idx;
    logic [4:0]    cur_ch;
    logic          wrap;
    logic          respond;
    logic          commit;

    assign busy_out = (state == ST_WAIT);
    assign cur_ch   = seq_ch(idx);
    assign wrap     = (conv_cnt == CW'(CONV_CYCLES - 1));
    assign respond  = (state == ST_WAIT) && (lat_cnt == 4'(LATENCY));
    // Only the config half (0x40-0x7F) is writable; status writes are acked and dropped
    assign commit   = respond && req_we && req_addr[6];

    // DRP transaction FSM: accept, count latency, respond
    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            state    <= ST_IDLE;
            lat_cnt  <= 4'd0;
            req_we   <= 1'b0;
            req_addr <= 7'd0;
            req_di   <= 16'd0;
            snap     <= 16'd0;
            do_out   <= 16'd0;
            drdy_out <= 1'b0;
            prot_err <= 1'b0;
        end else begin
            drdy_out <= 1'b0;
            if (den_in && busy_out) begin
                prot_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (den_in) begin
                        req_we   <= dwe_in;
                        req_addr <= daddr_in;
                        req_di   <= di_in;
                        // Pre-update value even if a conversion writes this address now
                        if (!dwe_in) begin
                            snap <= regs[daddr_in];
                        end
                        lat_cnt  <= 4'd1;
                        state    <= ST_WAIT;
                    end
                end
                default: begin
                    if (respond) begin
                        drdy_out <= 1'b1;
                        do_out   <= req_we ? 16'h0000 : snap;
                        lat_cnt  <= 4'd0;
                        state    <= ST_IDLE;
                    end else begin
                        lat_cnt  <= lat_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Register file: conversion results into status, committed DRP writes into config
    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            for (int i = 0; i < 128; i++) begin
                regs[i] <= 16'd0;
            end
        end else begin
            if (wrap) begin
                regs[{2'b00, cur_ch}] <= ch_data_in;
            end
            if (commit) begin
                regs[req_addr] <= req_di;
            end
        end
    end

    // Conversion sequencer: free-running period counter and sequence index
    always_ff @(posedge CLK100MHZ) begin
        if (reset_in) begin
            conv_cnt    <= '0;
            idx         <= 4'd0;
            eoc_out     <= 1'b0;
            eos_out     <= 1'b0;
            channel_out <= 5'd0;
        end else begin
            channel_out <= cur_ch;
            eoc_out     <= wrap;
            eos_out     <= wrap && (idx == 4'd8);
            if (wrap) begin
                conv_cnt <= '0;
                idx      <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
            end else begin
                conv_cnt <= conv_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed self-checking bench for xadc_drp_responder (LATENCY=4, CONV_CYCLES=8).
module tb_xadc_drp_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        busy;
    logic        prot_err;
    logic [15:0] ch_data;
    logic [4:0]  channel;
    logic        eoc;
    logic        eos;

    int checks   = 0;
    int failures = 0;

    xadc_drp_responder #(
        .LATENCY     (4),
        .CONV_CYCLES (8)
    ) dut (
        .CLK100MHZ   (clk),
        .reset_in    (reset),
        .den_in      (den),
        .dwe_in      (dwe),
        .daddr_in    (daddr),
        .di_in       (di),
        .do_out      (dout),
        .drdy_out    (drdy),
        .busy_out    (busy),
        .prot_err    (prot_err),
        .ch_data_in  (ch_data),
        .channel_out (channel),
        .eoc_out     (eoc),
        .eos_out     (eos)
    );

    always #5 clk = ~clk;

    // Expected sequence order
    function automatic logic [4:0] tbl(input int i);
        case (i)
            0: tbl = 5'h10;
            1: tbl = 5'h11;
            2: tbl = 5'h19;
            3: tbl = 5'h12;
            4: tbl = 5'h1A;
            5: tbl = 5'h1B;
            6: tbl = 5'h18;
            7: tbl = 5'h13;
            default: tbl = 5'h03;
        endcase
    endfunction

    function automatic int pos_of(input logic [4:0] ch);
        pos_of = 0;
        for (int i = 0; i < 9; i++) begin
            if (tbl(i) == ch) pos_of = i;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One DRP transaction; lat = negedges after the accept edge until drdy (20 = timeout)
    task automatic drp_xfer(input logic we, input logic [6:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat, output logic busy_seen,
                            output logic busy_at_rdy);
        @(negedge clk);
        den = 1'b1; dwe = we; daddr = addr; di = wdata;
        @(negedge clk);
        den = 1'b0; dwe = 1'b0;
        busy_seen = busy;
        lat = 0;
        while (!drdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = dout;
        busy_at_rdy = busy;
    endtask

    task automatic wait_eoc(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eoc && n < 40);
    endtask

    // Sample source: 0xA000 + sequence index of the channel now converting
    initial begin
        int cnt;
        cnt = 0;
        ch_data = 16'hA000;
        forever begin
            @(posedge clk);
            #1;
            if (reset) cnt = 0;
            else if (eoc) cnt = (cnt + 1) % 9;
            ch_data = 16'hA000 + 16'(cnt);
        end
    end

    initial begin
        logic [15:0] rd;
        logic        bs, br;
        int          lat, n, pulses, first;
        logic [15:0] exp;

        reset = 1'b1; den = 1'b0; dwe = 1'b0; daddr = 7'd0; di = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_do", 32'(dout), 32'h0);
        chk("rst_drdy", 32'(drdy), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_prot", 32'(prot_err), 32'h0);
        chk("rst_chan", 32'(channel), 32'h0);
        chk("rst_eoc", 32'(eoc), 32'h0);
        chk("rst_eos", 32'(eos), 32'h0);
        reset = 1'b0;

        // 1: read 0x40 after reset
        drp_xfer(1'b0, 7'h40, 16'h0, rd, lat, bs, br);
        chk("t1_busy_after_e0", 32'(bs), 32'h1);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_do", 32'(rd), 32'h0000);
        chk("t1_busy_at_drdy", 32'(br), 32'h0);
        @(negedge clk);
        chk("t1_drdy_one_cycle", 32'(drdy), 32'h0);
        repeat (10) @(negedge clk);

        // 2: config write/read, status write discarded
        drp_xfer(1'b1, 7'h45, 16'hBEEF, rd, lat, bs, br);
        chk("t2_wr_latency", 32'(lat), 32'd4);
        chk("t2_wr_do", 32'(rd), 32'h0000);
        drp_xfer(1'b0, 7'h45, 16'h0, rd, lat, bs, br);
        chk("t2_rd_45", 32'(rd), 32'hBEEF);
        drp_xfer(1'b1, 7'h10, 16'h1234, rd, lat, bs, br);
        chk("t2_wr10_latency", 32'(lat), 32'd4);
        drp_xfer(1'b0, 7'h10, 16'h0, rd, lat, bs, br);
        chk("t2_rd_10", 32'(rd), 32'hA000);

        // 3: sequence walk from a fresh reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wait_eoc(n);
            chk("t3_eoc_seen", 32'(eoc), 32'h1);
            if (k > 0) chk("t3_eoc_period", 32'(n), 32'd8);
            chk("t3_channel", 32'(channel), 32'(tbl(k)));
            chk("t3_eos", 32'(eos), (k == 8) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        chk("t3_eos_one_cycle", 32'(eos), 32'h0);
        drp_xfer(1'b0, 7'h19, 16'h0, rd, lat, bs, br);
        chk("t3_reg19", 32'(rd), 32'hA002);
        drp_xfer(1'b0, 7'h03, 16'h0, rd, lat, bs, br);
        chk("t3_reg03", 32'(rd), 32'hA008);

        // 4: den driven from eoc, reading the converted channel
        for (int k = 0; k < 9; k++) begin
            wait_eoc(n);
            chk("t4_eoc_seen", 32'(eoc), 32'h1);
            exp = 16'hA000 + 16'(pos_of(channel));
            den = 1'b1; dwe = 1'b0; daddr = {2'b00, channel};
            @(negedge clk);
            den = 1'b0;
            lat = 0;
            while (!drdy && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("t4_latency", 32'(lat), 32'd4);
            chk("t4_do", 32'(dout), 32'(exp));
        end
        chk("t4_prot_clear", 32'(prot_err), 32'h0);

        // 5: second den while busy
        @(negedge clk); den = 1'b1; dwe = 1'b0; daddr = 7'h45;
        @(negedge clk); den = 1'b0;
        @(negedge clk); den = 1'b1;
        @(negedge clk); den = 1'b0;
        pulses = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (drdy) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("t5_drdy_count", 32'(pulses), 32'd1);
        chk("t5_drdy_edge", 32'(first), 32'd1);
        chk("t5_prot_set", 32'(prot_err), 32'h1);
        repeat (5) @(negedge clk);
        chk("t5_prot_sticky", 32'(prot_err), 32'h1);

        // 6: reset mid-read aborts without drdy
        drp_xfer(1'b1, 7'h46, 16'h5A5A, rd, lat, bs, br);
        @(negedge clk); den = 1'b1; dwe = 1'b0; daddr = 7'h46;
        @(negedge clk); den = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_eoc", 32'(eoc), 32'h0);
        chk("t6_drdy", 32'(drdy), 32'h0);
        chk("t6_prot_cleared", 32'(prot_err), 32'h0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (drdy) pulses++;
        end
        chk("t6_no_drdy", 32'(pulses), 32'd0);
        drp_xfer(1'b0, 7'h46, 16'h0, rd, lat, bs, br);
        chk("t6_reg46_cleared", 32'(rd), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
